// File: rtl/button_repeat_conditioner_if.sv
// Button bundle between a host and the conditioner: raw levels in,
// debounced levels and press/repeat events out.
interface button_repeat_conditioner_if #(
  parameter int CH = 5
);
  logic [CH-1:0] in;
  logic [CH-1:0] level;
  logic [CH-1:0] pulse;
  logic          any_pulse;

  modport master (output in, input level, pulse, any_pulse);
  modport slave  (input in, output level, pulse, any_pulse);
endinterface

// File: rtl/button_repeat_conditioner.sv
// Multi-channel button debouncer with per-channel press/auto-repeat event
// generation and optional lowest-index-wins event arbitration.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | debounced level low, waiting for a press
// HELD_DELAY | pressed; counting the initial delay before auto-repeat
// REPEAT     | auto-repeating; one event every REPEAT_PERIOD cycles
module button_repeat_conditioner #(
  parameter int            CH            = 5,
  parameter int            DB_LEN        = 8,
  parameter int            REPEAT_DELAY  = 12_500_000,
  parameter int            REPEAT_PERIOD = 2_500_000,
  parameter logic [CH-1:0] REPEAT_MASK   = '1,
  parameter int            EXCLUSIVE     = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  button_repeat_conditioner_if.slave  btn
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    HELD_DELAY = 2'd1,
    REPEAT     = 2'd2
  } state_t;

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] DELAY_TC  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_TC = CW'(REPEAT_PERIOD - 1);

  logic [CH-1:0] level_q;
  logic [CH-1:0] req;
  logic [CH-1:0] pulse_d;
  logic [CH-1:0] pulse_q;
  logic          any_pulse_q;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [DB_LEN-1:0] shift_q;
    logic              lvl_q;
    logic              lvl_d;
    state_t            state_q;
    state_t            state_d;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;
    logic              req_c;

    always_ff @(posedge clk) begin
      if (rst) begin
        shift_q <= '0;
        lvl_q   <= 1'b0;
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        shift_q <= {shift_q[DB_LEN-2:0], btn.in[i]};
        lvl_q   <= lvl_d;
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // Hysteresis: only a unanimous register moves the level.
    always_comb begin
      lvl_d = lvl_q;
      if (&shift_q) begin
        lvl_d = 1'b1;
      end else if (~|shift_q) begin
        lvl_d = 1'b0;
      end
    end

    // The FSM looks at the next level so the first event lands on the same
    // edge as the level rise, and a release beats a coincident terminal count.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_c   = 1'b0;
      if (!lvl_d) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          IDLE: begin
            state_d = HELD_DELAY;
            cnt_d   = '0;
            req_c   = 1'b1;
          end
          HELD_DELAY: begin
            if (cnt_q == DELAY_TC) begin
              if (REPEAT_MASK[i]) begin
                state_d = REPEAT;
                cnt_d   = '0;
                req_c   = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          REPEAT: begin
            if (cnt_q == PERIOD_TC) begin
              cnt_d = '0;
              req_c = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          default: begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end

    assign level_q[i] = lvl_q;
    assign req[i]     = req_c;
  end

  // Losing channels are dropped outright; their FSMs are unaffected.
  always_comb begin
    pulse_d = req;
    if (EXCLUSIVE != 0) begin
      pulse_d = req & (~req + CH'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_q     <= '0;
      any_pulse_q <= 1'b0;
    end else begin
      pulse_q     <= pulse_d;
      any_pulse_q <= |pulse_d;
    end
  end

  assign btn.level     = level_q;
  assign btn.pulse     = pulse_q;
  assign btn.any_pulse = any_pulse_q;

endmodule
